// File: rtl/fp32_pkg.sv
// ============================================================================
//  fp32_pkg -- shared binary32 constants and field layout for the FP32 adder
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fp32_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

`default_nettype wire

// File: rtl/fp32_lzc.sv
// ============================================================================
//  fp32_lzc -- 27-bit leading-zero counter; an all-zero input yields 27
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp32_lzc (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    // Ascending scan: the most significant set bit is the last one to write.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp32_adder.sv
// ============================================================================
//  fp32_adder -- binary32 adder, round-to-nearest-even, one registered stage
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp32_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] sum
);

    fp32_t       w_a, w_b, w_big, w_sml;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_swap, w_eff_sub, w_rnd_up;
    logic [7:0]  w_big_e, w_sml_e, w_diff, w_emax;
    logic [26:0] w_big_m, w_sml_m0, w_sml_m, w_norm_m;
    logic [52:0] w_sml_sh;
    logic [27:0] w_raw;
    logic [4:0]  w_lz, w_shift;
    logic [9:0]  w_norm_e, w_fin_e;
    logic [24:0] w_rnd_m;
    logic [22:0] w_fin_man;
    logic [31:0] w_result;

    assign w_a      = a;
    assign w_b      = b;
    assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.man != '0);
    assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.man != '0);
    assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.man == '0);
    assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.man == '0);
    assign w_a_zero = (a[30:0] == 31'd0);
    assign w_b_zero = (b[30:0] == 31'd0);

    // Magnitude ordering on the packed exp|man field; ties keep a as larger.
    assign w_swap    = b[30:0] > a[30:0];
    assign w_big     = w_swap ? w_b : w_a;
    assign w_sml     = w_swap ? w_a : w_b;
    assign w_big_e   = (w_big.exp == 8'd0) ? 8'd1 : w_big.exp;
    assign w_sml_e   = (w_sml.exp == 8'd0) ? 8'd1 : w_sml.exp;
    assign w_diff    = w_big_e - w_sml_e;
    assign w_big_m   = {w_big.exp != 8'd0, w_big.man, 3'b000};
    assign w_sml_m0  = {w_sml.exp != 8'd0, w_sml.man, 3'b000};
    assign w_sml_sh  = {w_sml_m0, 26'd0} >> w_diff;
    assign w_sml_m   = (w_diff >= 8'd26) ? {26'd0, |w_sml_m0}
                                         : {w_sml_sh[52:27], w_sml_sh[26] | (|w_sml_sh[25:0])};

    assign w_eff_sub = w_big.sign ^ w_sml.sign;
    assign w_raw     = w_eff_sub ? ({1'b0, w_big_m} - {1'b0, w_sml_m})
                                 : ({1'b0, w_big_m} + {1'b0, w_sml_m});

    fp32_lzc u_lzc (
        .value (w_raw[26:0]),
        .count (w_lz)
    );

    // Left shift is capped so the exponent bottoms out at 1 (subnormal result).
    assign w_emax  = w_big_e - 8'd1;
    assign w_shift = ({3'b000, w_lz} > w_emax) ? w_emax[4:0] : w_lz;

    always_comb begin
        if (w_raw[27]) begin
            w_norm_m = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_norm_e = {2'b00, w_big_e} + 10'd1;
        end else begin
            w_norm_m = w_raw[26:0] << w_shift;
            w_norm_e = {2'b00, w_big_e} - {5'd0, w_shift};
        end
    end

    assign w_rnd_up  = w_norm_m[2] & (w_norm_m[1] | w_norm_m[0] | w_norm_m[3]);
    assign w_rnd_m   = {1'b0, w_norm_m[26:3]} + {24'd0, w_rnd_up};
    assign w_fin_e   = w_rnd_m[24] ? (w_norm_e + 10'd1) : (w_rnd_m[23] ? w_norm_e : 10'd0);
    assign w_fin_man = w_rnd_m[24] ? w_rnd_m[23:1] : w_rnd_m[22:0];

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            w_result = QNAN;
        end else if (w_a_inf) begin
            w_result = a;
        end else if (w_b_inf) begin
            w_result = b;
        end else if (w_a_zero && w_b_zero) begin
            w_result = {w_a.sign & w_b.sign, 31'd0};
        end else if (w_a_zero) begin
            w_result = b;
        end else if (w_b_zero) begin
            w_result = a;
        end else if (w_raw == 28'd0) begin
            w_result = 32'd0;
        end else if (w_fin_e >= 10'd255) begin
            w_result = w_big.sign ? NEG_INF : POS_INF;
        end else begin
            w_result = {w_big.sign, w_fin_e[7:0], w_fin_man};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= 32'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= w_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp32_adder.sv
// ============================================================================
//  tb_fp32_adder -- directed and random checks against an exact-integer model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp32_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] sum;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_sum = 32'd0;

    always #5 clk = ~clk;

    fp32_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum)
    );

    // Operands become exact integers in units of 2^-149, are summed exactly,
    // then rounded back to binary32 with round-half-even.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic [299:0]        mx, my, mag, q, rem, half;
        logic signed [299:0] vx, vy, tot;
        int                  ex, ey, p, sh;
        logic                sgn;
        if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0))
            return 32'h7FC0_0000;
        if (x[30:0] == 31'h7F80_0000 && y[30:0] == 31'h7F80_0000)
            return (x[31] == y[31]) ? x : 32'h7FC0_0000;
        if (x[30:0] == 31'h7F80_0000) return x;
        if (y[30:0] == 31'h7F80_0000) return y;
        if (x[30:0] == 0 && y[30:0] == 0) return {x[31] & y[31], 31'd0};
        ex  = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ey  = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        mx  = {276'd0, x[30:23] != 0, x[22:0]};
        my  = {276'd0, y[30:23] != 0, y[22:0]};
        vx  = $signed(mx << (ex - 1));
        vy  = $signed(my << (ey - 1));
        if (x[31]) vx = -vx;
        if (y[31]) vy = -vy;
        tot = vx + vy;
        if (tot == 0) return 32'd0;
        sgn = tot < 0;
        mag = sgn ? 300'(-tot) : 300'(tot);
        p = 0;
        for (int i = 299; i >= 0; i--) begin
            if (mag[i]) begin
                p = i;
                break;
            end
        end
        if (p <= 23) return {sgn, mag[30:0]};
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 300'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 300'd1;
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        if (sh + 1 >= 255) return sgn ? 32'hFF80_0000 : 32'h7F80_0000;
        return {sgn, 8'(sh + 1), q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y, input string tag);
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (v) exp_sum = ref_add(x, y);
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v});
        check(tag, sum, exp_sum);
    endtask

    task automatic vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv,
                       input string tag);
        step(1'b1, x, y, tag);
        check({tag, " literal"}, sum, expv);
    endtask

    initial begin
        logic [31:0] x, y, r;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h4040_0000;
        b        = 32'h4070_0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset sum", sum, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        vec(32'h4040_0000, 32'h4070_0000, 32'h40D8_0000, "normal");
        vec(32'h4040_0000, 32'hC070_0000, 32'hBF40_0000, "mixed sign");
        vec(32'h0000_0000, 32'h4070_0000, 32'h4070_0000, "zero operand");
        vec(32'h7F80_0000, 32'hBF80_0000, 32'h7F80_0000, "inf plus finite");
        vec(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf minus inf");
        vec(32'h7F80_0001, 32'h4070_0000, 32'h7FC0_0000, "nan input");
        vec(32'h7F7F_FFFF, 32'h0080_0000, 32'h7F7F_FFFF, "absorption");
        vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
        vec(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie to even");
        vec(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "tie round up");
        vec(32'h4040_0000, 32'hC040_0000, 32'h0000_0000, "cancellation");
        vec(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, "subnormal sum");
        vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "neg zeros");
        vec(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, "mixed zeros");
        vec(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, "neg infs");
        vec(32'h807F_FFFF, 32'h8000_0001, 32'h8080_0000, "subnormal to normal");

        step(1'b0, 32'h4000_0000, 32'h4000_0000, "idle hold");

        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            r = $urandom;
            case (i % 4)
                0: y = $urandom;
                1: y = {r[31], x[30:23] + {5'd0, r[2:0]} - 8'd3, r[25:3]};
                2: begin
                    x = {x[31], 8'h00, x[22:0]};
                    y = r & 32'h80FF_FFFF;
                end
                default: y = {~x[31], x[30:0] ^ {29'd0, r[2:0]}};
            endcase
            step(1'b1, x, y, "random");
            if (r[31:28] == 4'hF) step(1'b0, r, x, "random idle");
        end

        step(1'b1, 32'h3F80_0000, 32'h4000_0000, "pre-reset");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h4110_0000;
        b        = 32'h4120_0000;
        @(posedge clk);
        #1;
        exp_sum = 32'd0;
        check("mid-stream reset sum", sum, 32'd0);
        check("mid-stream reset out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vec(32'h4110_0000, 32'h4120_0000, 32'h4198_0000, "first after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
